// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Half-period H means the output toggles every H+1 system clock cycles.
package clk_div_pkg;

  localparam int unsigned SYS_CLK_HZ         = 50_000_000;
  localparam int unsigned DEFAULT_HALF_100HZ = 249_999;

  function automatic int unsigned half_for_hz(input int unsigned f);
    return SYS_CLK_HZ / (2 * f) - 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Config port of clk_div_multi: one half-period write per valid/ready transfer.
// The slave drives cfg_ready combinationally from the selected channel's pending flag.
interface clk_div_multi_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;

  modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: registered square wave plus rising-edge tick, 1-cycle registered outputs.
// Accepts a new half-period only while nothing is pending (ready_o = ~pend).
module clk_div_channel import clk_div_pkg::*; #(
  parameter int          CNT_W    = 24,
  parameter int unsigned HALF_RST = DEFAULT_HALF_100HZ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             ready_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_cur_q, half_cur_d;
  logic [CNT_W-1:0] half_nxt_q, half_nxt_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             boundary;

  assign boundary = en_i && (cnt_q == half_cur_q);

  always_comb begin
    cnt_d      = cnt_q;
    half_cur_d = half_cur_q;
    half_nxt_d = half_nxt_q;
    pend_d     = pend_q;
    out_d      = out_q;
    tick_d     = 1'b0;

    if (!en_i) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (boundary) begin
      cnt_d  = '0;
      out_d  = ~out_q;
      tick_d = ~out_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Pending value swaps in only where no half-period is in flight.
    if (pend_q && (!en_i || boundary)) begin
      half_cur_d = half_nxt_q;
      pend_d     = 1'b0;
    end

    if (load_i) begin
      half_nxt_d = half_i;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      half_cur_q <= CNT_W'(HALF_RST);
      half_nxt_q <= '0;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      half_cur_q <= half_cur_d;
      half_nxt_q <= half_nxt_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
    end
  end

  assign ready_o = ~pend_q;
  assign clk_o   = out_q;
  assign tick_o  = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent clock dividers with a shared config port; outputs registered, 1-cycle latency.
// cfg_ready mirrors the addressed channel's free slot; out-of-range channels accept and discard.
module clk_div_multi import clk_div_pkg::*; #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 24,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_100HZ,
  parameter int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  clk_div_multi_if.slave    cfg,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] ch_rdy;
  logic [NUM_CH-1:0] ch_load;
  logic              rdy_sel;

  always_comb begin
    rdy_sel = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) rdy_sel = ch_rdy[i];
    end
  end

  always_comb begin
    ch_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_load[i] = cfg.cfg_valid && rdy_sel && (cfg.cfg_ch == CH_W'(i));
    end
  end

  assign cfg.cfg_ready = rdy_sel;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W    (CNT_W),
      .HALF_RST (DEFAULT_HALF)
    ) u_ch (
      .clk_i   (clk_50MHz),
      .rst_i   (rst),
      .en_i    (ch_en[g]),
      .load_i  (ch_load[g]),
      .half_i  (cfg.cfg_half),
      .ready_o (ch_rdy[g]),
      .clk_o   (clk_out[g]),
      .tick_o  (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi with NUM_CH=2, DEFAULT_HALF=4; reference model tracks phase lengths.
module tb_clk_div_multi;

  localparam int DEF = 4;

  logic       clk_50MHz = 1'b0;
  logic       rst;
  logic [1:0] ch_en;
  logic [1:0] clk_out;
  logic [1:0] tick;

  clk_div_multi_if #(.CH_W(2), .CNT_W(8)) cfg ();

  clk_div_multi #(
    .NUM_CH       (2),
    .CNT_W        (8),
    .DEFAULT_HALF (DEF),
    .CH_W         (2)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .cfg       (cfg),
    .ch_en     (ch_en),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int total = 0;
  int bad   = 0;

  // Model: cycles elapsed in the current phase, phase length (H+1), queued length.
  int m_done[2] = '{0, 0};
  int m_len[2]  = '{DEF + 1, DEF + 1};
  int m_plen[2] = '{0, 0};
  bit m_pend[2] = '{0, 0};
  bit m_lvl[2]  = '{0, 0};
  bit m_tk[2]   = '{0, 0};

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] exp_clk;
    logic [1:0] exp_tick;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[16];

  function automatic bit m_ready(input logic [1:0] c);
    if (c > 2'd1) return 1'b1;
    return !m_pend[c];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit xfer[2];
    for (int i = 0; i < 2; i++)
      xfer[i] = cfg.cfg_valid && (cfg.cfg_ch == 2'(i)) && !m_pend[i];
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_done[i] = 0; m_len[i] = DEF + 1; m_pend[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
      end else begin
        m_tk[i] = 0;
        if (!ch_en[i]) begin
          m_done[i] = 0;
          m_lvl[i]  = 0;
          if (m_pend[i]) begin m_len[i] = m_plen[i]; m_pend[i] = 0; end
        end else begin
          m_done[i]++;
          if (m_done[i] == m_len[i]) begin
            m_done[i] = 0;
            m_lvl[i]  = !m_lvl[i];
            m_tk[i]   = m_lvl[i];
            if (m_pend[i]) begin m_len[i] = m_plen[i]; m_pend[i] = 0; end
          end
        end
        if (xfer[i]) begin m_plen[i] = int'(cfg.cfg_half) + 1; m_pend[i] = 1; end
      end
    end
  endtask

  task automatic step();
    @(negedge clk_50MHz);
    chk("ready", 32'(cfg.cfg_ready), 32'(m_ready(cfg.cfg_ch)));
    @(posedge clk_50MHz);
    model_edge();
    #1;
    chk("clk_out", 32'(clk_out), 32'({m_lvl[1], m_lvl[0]}));
    chk("tick", 32'(tick), 32'({m_tk[1], m_tk[0]}));
  endtask

  task automatic measure(input int c, output int n);
    logic lvl;
    lvl = clk_out[c];
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out[c] == lvl && n < 100);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] h);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = c;
    cfg.cfg_half  = h;
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    int w;

    vecs[0] = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b1};
    for (int k = 1; k <= 4; k++)   vecs[k] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    vecs[5] = '{1'b0, 2'b11, 2'b11, 2'b11, 1'b1};
    for (int k = 6; k <= 9; k++)   vecs[k] = '{1'b0, 2'b11, 2'b11, 2'b00, 1'b1};
    for (int k = 10; k <= 14; k++) vecs[k] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    vecs[15] = '{1'b0, 2'b11, 2'b11, 2'b11, 1'b1};

    rst = 1'b1;
    ch_en = 2'b00;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = 2'd0;
    cfg.cfg_half  = 8'd0;
    repeat (2) @(posedge clk_50MHz);
    #1;

    // Reset state and the default 10-cycle period with aligned ticks.
    for (int k = 0; k < 16; k++) begin
      rst   = vecs[k].rst;
      ch_en = vecs[k].en;
      step();
      chk("tbl_clk", 32'(clk_out), 32'(vecs[k].exp_clk));
      chk("tbl_tick", 32'(tick), 32'(vecs[k].exp_tick));
      chk("tbl_rdy", 32'(cfg.cfg_ready), 32'(vecs[k].exp_rdy));
    end

    // ch0 H=1 written mid-high: high phase still completes, then period 4.
    send(2'd0, 8'd1);
    #1;
    chk("A_rdy_low", 32'(cfg.cfg_ready), 32'd0);
    measure(0, n); chk("A_hi_rest", n, 4);
    measure(0, n); chk("A_lo2", n, 2);
    measure(0, n); chk("A_hi2", n, 2);
    measure(1, n); chk("A_ch1_rise", n, 1);

    // Second write to ch0 stalls until the applying boundary.
    send(2'd0, 8'd3);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 8'd2;
    w = 0;
    while (!cfg.cfg_ready && w < 20) begin step(); w++; end
    chk("B_stall", w, 2);
    step();
    cfg.cfg_valid = 1'b0;

    // Transfer on a ch1 boundary: next half keeps old length, then 3.
    measure(1, n);
    repeat (4) step();
    send(2'd1, 8'd2);
    measure(1, n); chk("C_old_half", n, 5);
    measure(1, n); chk("C_new_half1", n, 3);
    measure(1, n); chk("C_new_half2", n, 3);

    // Disable ch0 with H=7 pending, then re-enable.
    cfg.cfg_ch = 2'd0;
    #1;
    w = 0;
    while (!cfg.cfg_ready && w < 20) begin step(); w++; end
    send(2'd0, 8'd7);
    ch_en = 2'b10;
    step();
    #1;
    chk("D_off", 32'(clk_out[0]), 32'd0);
    chk("D_rdy", 32'(cfg.cfg_ready), 32'd1);
    repeat (3) step();
    chk("D_off_hold", 32'(clk_out[0]), 32'd0);
    ch_en = 2'b11;
    measure(0, n); chk("D_first_rise", n, 8);
    measure(0, n); chk("D_high", n, 8);

    // Out-of-range channel is accepted and discarded.
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd3;
    cfg.cfg_half  = 8'd0;
    #1;
    chk("E_oor_rdy", 32'(cfg.cfg_ready), 32'd1);
    step();
    cfg.cfg_valid = 1'b0;
    measure(1, n);
    measure(1, n); chk("E_ch1_keep", n, 3);

    // Reset during a transfer wins.
    rst = 1'b1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd0;
    cfg.cfg_half  = 8'd1;
    step();
    chk("F_rst_clk", 32'(clk_out), 32'd0);
    chk("F_rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    cfg.cfg_valid = 1'b0;
    measure(0, n); chk("F_lo", n, 5);
    measure(0, n); chk("F_hi", n, 5);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rst           = ($urandom_range(0, 199) == 0);
      ch_en         = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
      cfg.cfg_valid = ($urandom_range(0, 2) == 0);
      cfg.cfg_ch    = 2'($urandom_range(0, 3));
      cfg.cfg_half  = 8'($urandom_range(0, 6));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider generating NUM_CH independent square-wave outputs from the 50 MHz system clock. Each channel has a runtime-programmable half-period, a per-channel enable and a one-cycle rising-edge tick. Half-period updates arrive over a valid/ready config port and are applied glitch-free on the next toggle boundary. The block serves as the shared timebase generator for slow logic such as 100 Hz scan, debounce and blink domains.

## Interface
- NUM_CH, 4, number of divider channels (≥1)
- CNT_W, 24, counter and half-period width
- DEFAULT_HALF, 249999, reset half-period; 50 MHz / (2·250000) = 100 Hz
- CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived)

Ports (clock and reset first):
- clk_50MHz  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid && cfg_ready
- cfg_ch  in  CH_W  target channel
- cfg_half  in  CNT_W  new half-period value H; output toggles every H+1 cycles
- ch_en  in  NUM_CH  per-channel run enable
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse, high in the first cycle clk_out[i] is 1

## Operation
- Per-channel state:
  - cnt (CNT_W)
  - half_cur (CNT_W)
  - half_nxt (CNT_W)
  - pend (1)
  - out (1)
- Reset values: cnt=0, half_cur=DEFAULT_HALF, half_nxt=0, pend=0, clk_out=0, tick=0. Reset overrides every other input, including a cfg transfer in the same cycle.
- Enabled channel, counting:
  - cnt≠half_cur: cnt+1.
  - cnt==half_cur (boundary): cnt←0, out toggles.
  - If pend is set at a boundary, half_cur←half_nxt and pend←0 in the same edge, so the new value governs the following half-period.
- H=0 gives clk_50MHz/2. Period is 2·(H+1) cycles; duty cycle is exactly 50%.
- cfg_ready = ~pend[cfg_ch], combinational. An out-of-range cfg_ch (≥NUM_CH) reads ready=1 and the transfer is discarded.
- Transfer: half_nxt[cfg_ch]←cfg_half, pend←1.
- Transfer coinciding with a boundary on the same channel: the boundary uses the old half_cur, and the new value is applied at the next boundary.
- Disabled channel (ch_en[i]=0):
  - cnt held at 0, out←0, tick←0.
  - A pending value is applied immediately: half_cur←half_nxt, pend←0 on the next edge.
- Re-enable: counting starts from cnt=0. The first rising edge of clk_out occurs H+1 cycles after the first enabled cycle.
- Disable mid-period: out drops to 0 on the next edge, possibly truncating a high phase. This is accepted; the glitch-free guarantee applies only to updates.
- Channels are fully independent; one transfer per cycle.

## Timing
- clk_out and tick are registered, with no combinational path from inputs to them.
- tick[i] is high in exactly the cycle clk_out[i] first reads 1.
- Config latency: a transfer at cycle t takes effect at the first boundary strictly after t. The maximum delay is half_cur+1 cycles.
- cfg_ready for a channel falls the cycle after acceptance and rises the cycle after the applying boundary (or disable).

## Structure
- Package clk_div_pkg holds:
  - DEFAULT_HALF_100HZ = 249999
  - SYS_CLK_HZ = 50_000_000
  - function half_for_hz(f) = SYS_CLK_HZ/(2f) − 1
- Sub-module clk_div_channel holds cnt, half_cur, half_nxt, pend, out and tick for one channel, instantiated NUM_CH times by generate.
- The top level holds only cfg decode and the ready mux.

## Test plan
Sim uses NUM_CH=2, DEFAULT_HALF=4.
- Reset, ch_en=2'b11 → clk_out low for 5 cycles, then high for 5, period 10; tick pulses every 10 cycles aligned to the rising edge.
- Write ch0 H=1 mid-high-phase → current half-period completes at 5 cycles, then period 4; ch1 is unaffected.
- Second cfg_valid to ch0 while pend → cfg_ready=0 until the boundary, then accepted.
- Transfer on the same cycle as a ch1 boundary with H=2 → next half-period is still 5, following halves are 3.
- ch_en[0]=0 mid-period with H=7 pending → clk_out[0]=0 next cycle, cfg_ready high next cycle. On re-enable the first rise comes after 8 cycles.
- cfg_ch=3 (out of range) with valid → ready=1, no channel changes; rst asserted during a transfer → all outputs 0, half_cur=4.
